// File: rtl/cordic_seq_ctrl.sv
// Control FSM sequencing one CORDIC operation: operand accept/load, NITER micro-rotations
// driven through an external iteration counter, then result presentation under valid/ready.
module cordic_seq_ctrl #(
  parameter int unsigned NITER = 16,
  parameter int unsigned CW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          abort,
  input  logic [CW-1:0] count,
  output logic          cnt_start,
  output logic          cnt_enable,
  output logic          load,
  output logic          iter_en,
  output logic          iter_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  // NITER == 2**CW truncates cleanly to all-ones.
  localparam logic [CW-1:0] LastCount = CW'(NITER - 1);

  state_e state_q, state_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    cnt_start  = 1'b0;
    cnt_enable = 1'b0;
    load       = 1'b0;
    iter_en    = 1'b0;
    iter_last  = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;

    if (reset) begin
      // While reset is held the block looks idle and refuses to start an operation.
      in_ready = 1'b1;
      state_d  = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready = 1'b1;
          if (in_valid) begin
            load       = 1'b1;
            cnt_start  = 1'b1;
            cnt_enable = 1'b1;
            state_d    = StIter;
          end
        end
        StIter: begin
          busy       = 1'b1;
          cnt_enable = 1'b1;
          iter_last  = (count == LastCount);
          if (abort) begin
            state_d = StIdle;
          end else begin
            iter_en = 1'b1;
            if (iter_last) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          busy = 1'b1;
          if (abort) begin
            state_d = StIdle;
          end else begin
            out_valid = 1'b1;
            if (out_ready) begin
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Randomised + directed bench for cordic_seq_ctrl: per-cycle expectations from an operation-level
// model are queued by the driver and compared by an independent monitor on the falling edge.
module tb_cordic_seq_ctrl;

  localparam int unsigned N  = 16;
  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count = '0;
  logic          in_ready, cnt_start, cnt_enable, load, iter_en, iter_last, out_valid, busy;

  // Second instance exercising NITER = 1.
  logic          reset1 = 1'b1;
  logic          in_valid1 = 1'b0;
  logic          out_ready1 = 1'b1;
  logic [CW-1:0] count1 = '0;
  logic          in_ready1, cnt_start1, cnt_enable1, load1, iter_en1, iter_last1, out_valid1, busy1;

  always #5 clock = ~clock;

  cordic_seq_ctrl #(.NITER(N), .CW(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .abort      (abort),
    .count      (count),
    .cnt_start  (cnt_start),
    .cnt_enable (cnt_enable),
    .load       (load),
    .iter_en    (iter_en),
    .iter_last  (iter_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  cordic_seq_ctrl #(.NITER(1), .CW(CW)) dut1 (
    .clock      (clock),
    .reset      (reset1),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .abort      (1'b0),
    .count      (count1),
    .cnt_start  (cnt_start1),
    .cnt_enable (cnt_enable1),
    .load       (load1),
    .iter_en    (iter_en1),
    .iter_last  (iter_last1),
    .out_valid  (out_valid1),
    .out_ready  (out_ready1),
    .busy       (busy1)
  );

  // External iteration counters, as the datapath would implement them.
  always @(posedge clock) begin
    if (cnt_enable) count <= cnt_start ? '0 : count + 4'd1;
    if (cnt_enable1) count1 <= cnt_start1 ? '0 : count1 + 4'd1;
  end

  typedef struct packed {
    logic in_ready, cnt_start, cnt_enable, load, iter_en, iter_last, out_valid, busy;
  } outs_t;

  typedef struct {
    outs_t         val;
    outs_t         care;
    bit            cnt_care;
    logic [CW-1:0] cnt;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Operation-level model: is an operation in flight, and how many iterations has it finished.
  bit m_active = 1'b0;
  int m_iters  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Drive one cycle of inputs (just after the rising edge) and queue what the DUT must show.
  task automatic issue(input bit r, input bit iv, input bit ab, input bit ordy);
    exp_t e;
    @(posedge clock);
    #1;
    reset = r; in_valid = iv; abort = ab; out_ready = ordy;
    e.val = '0; e.care = '1; e.cnt_care = 1'b0; e.cnt = '0; e.cyc = cyc;
    if (r) begin
      e.val.in_ready = 1'b1;
      m_active = 1'b0;
    end else if (!m_active) begin
      e.val.in_ready = 1'b1;
      if (iv) begin
        e.val.load = 1'b1; e.val.cnt_start = 1'b1; e.val.cnt_enable = 1'b1;
        m_active = 1'b1; m_iters = 0;
      end
    end else if (m_iters < N) begin
      e.val.busy = 1'b1;
      e.cnt_care = 1'b1;
      e.cnt = CW'(m_iters);
      if (ab) begin
        // Counter enable and last flag are not meaningful for an aborted iteration.
        e.care.cnt_enable = 1'b0; e.care.iter_last = 1'b0;
        m_active = 1'b0;
      end else begin
        e.val.iter_en = 1'b1; e.val.cnt_enable = 1'b1;
        e.val.iter_last = (m_iters == N - 1);
        m_iters++;
      end
    end else begin
      e.val.busy = 1'b1;
      e.cnt_care = 1'b1;
      e.cnt = CW'(N);
      e.val.out_valid = !ab;
      if (ab || ordy) m_active = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare each queued expectation against the settled outputs.
  initial begin
    exp_t e;
    outs_t act;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {in_ready, cnt_start, cnt_enable, load, iter_en, iter_last, out_valid, busy};
        checks++;
        if (((act ^ e.val) & e.care) != '0) begin
          errors++;
          $display("FAIL cyc%0d outputs: got %b expected %b (care %b)", e.cyc, act, e.val, e.care);
        end
        if (e.cnt_care) begin
          checks++;
          if (count !== e.cnt) begin
            errors++;
            $display("FAIL cyc%0d count: got %0d expected %0d", e.cyc, count, e.cnt);
          end
        end
      end
    end
  end

  task automatic run_to_done(input bit ordy);
    for (int i = 0; i < N + 2 && m_active && m_iters < N; i++) issue(0, 0, 0, ordy);
  endtask

  initial begin
    issue(1, 0, 0, 0);
    issue(1, 1, 0, 1);

    // Single operation, out_ready high.
    issue(0, 1, 0, 1);
    for (int i = 0; i < N + 3; i++) issue(0, 0, 0, 1);

    // Backpressure in DONE for 5 cycles.
    issue(0, 1, 0, 0);
    run_to_done(0);
    for (int i = 0; i < 5; i++) issue(0, 0, 0, 0);
    issue(0, 0, 0, 1);
    issue(0, 0, 0, 1);

    // Back-to-back with in_valid held high.
    for (int i = 0; i < 3 * (N + 2) + 2; i++) issue(0, 1, 0, 1);
    issue(0, 0, 0, 1);
    run_to_done(1);
    issue(0, 0, 0, 1);
    issue(0, 0, 0, 1);

    // Abort at count 7.
    issue(0, 1, 0, 1);
    for (int i = 0; i < N && m_iters != 7; i++) issue(0, 0, 0, 1);
    issue(0, 0, 1, 1);
    issue(0, 0, 0, 1);

    // Abort together with out_ready in DONE.
    issue(0, 1, 0, 0);
    run_to_done(0);
    issue(0, 0, 1, 1);
    issue(0, 0, 0, 1);

    // Reset at count 10, then a full operation.
    issue(0, 1, 0, 1);
    for (int i = 0; i < N && m_iters != 10; i++) issue(0, 0, 0, 1);
    issue(1, 0, 0, 1);
    issue(0, 1, 0, 1);
    for (int i = 0; i < N + 3; i++) issue(0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      issue($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0);
    issue(0, 0, 1, 1);
    issue(0, 0, 0, 1);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);

    // NITER = 1 instance.
    @(posedge clock); #1;
    reset1 = 1'b0; in_valid1 = 1'b1;
    @(negedge clock);
    chk("n1_load", load1, 1);
    chk("n1_cnt_start", cnt_start1, 1);
    chk("n1_in_ready_idle", in_ready1, 1);
    @(posedge clock); #1;
    in_valid1 = 1'b0;
    @(negedge clock);
    chk("n1_iter_en", iter_en1, 1);
    chk("n1_iter_last", iter_last1, 1);
    chk("n1_count", count1, 0);
    chk("n1_in_ready_iter", in_ready1, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("n1_out_valid", out_valid1, 1);
    chk("n1_iter_en_done", iter_en1, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("n1_idle_in_ready", in_ready1, 1);
    chk("n1_idle_out_valid", out_valid1, 0);
    chk("n1_idle_busy", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
